pc_fetch_queue: RTL and testbench
=================================

PC_FETCH_QUEUE -- requirements
Module: pc_fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the fetch address loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Parameter DEPTH, default 4, is the instruction queue entries; it SHALL be a power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address; stable while imem_req is high.
REQ-007 imem_ack  input  1  one-cycle pulse; imem_rdata is valid and the request completes.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  queue head holds an instruction.
REQ-010 instr  output  32  head instruction word, feeds the IF/ID register.
REQ-011 instr_pc  output  32  address of the head instruction.
REQ-012 instr_ready  input  1  consumer accepts the head; driven from core PCWrite / IF_ID_Write, low during load-use stall.
REQ-013 redirect  input  1  one-cycle pulse; discard all fetched and in-flight instructions.
REQ-014 redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as zero.

Function
REQ-015 State: fetch_pc (32b), circular queue of DEPTH {pc, instr} entries, read/write pointers, count (0..DEPTH), FSM {RUN, WAIT_ACK, DROP}.
REQ-016 At most one memory request SHALL be outstanding.
REQ-017 RUN: if count < DEPTH and redirect is low, assert imem_req with imem_addr = fetch_pc, and go to WAIT_ACK next cycle.
REQ-018 WAIT_ACK: hold imem_req high and imem_addr unchanged until imem_ack.
REQ-019 On imem_ack in WAIT_ACK with no redirect: push {fetch_pc, imem_rdata}, set fetch_pc to fetch_pc + 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), and return to RUN.
REQ-020 On the ack cycle, RUN's issue condition SHALL be re-evaluated the next cycle; at most one request is issued per two cycles.
REQ-021 A request SHALL issue only when count plus outstanding is less than DEPTH, so a push never occurs when the queue is full.
REQ-022 instr_valid = (count != 0); instr and instr_pc come from the head entry; when the queue is empty, both are 0.
REQ-023 Pop occurs on instr_valid & instr_ready & ~redirect.
REQ-024 Simultaneous push and pop SHALL leave count unchanged.
REQ-025 Pointers wrap modulo DEPTH.
REQ-026 Latency: ack at cycle N makes the instruction visible on instr/instr_valid at cycle N+1 if the queue was empty.
REQ-027 Redirect has priority over push and pop: count goes to 0 and fetch_pc to {redirect_pc[31:2], 2'b00} on the next edge.
REQ-028 Redirect in RUN: no request issues that cycle; remain in RUN.
REQ-029 Redirect in WAIT_ACK without ack: go to DROP; imem_req and imem_addr stay held (memory handshake is never abandoned).
REQ-030 DROP: on imem_ack, discard imem_rdata, do not change fetch_pc, and go to RUN.
REQ-031 Redirect coincident with imem_ack in WAIT_ACK: discard the data and go to RUN.
REQ-032 A second redirect in DROP SHALL update fetch_pc to its target and remain in DROP.
REQ-033 instr_ready while instr_valid is low SHALL have no effect.

Reset
REQ-034 While rst_n is low, the following SHALL hold immediately (asynchronously): imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, count=0, pointers=0, FSM=RUN, fetch_pc=RESET_PC.
REQ-035 Reset during WAIT_ACK or DROP SHALL abandon the request; any imem_ack while or after rst_n is low, before a new request issues, SHALL be ignored.
REQ-036 The first request SHALL issue in the first cycle after rst_n deasserts.

Verification
REQ-037 Reset release, ack one cycle after each request, instr_ready=1 -> imem_addr sequence 0,4,8,C; instr_pc follows one cycle after each ack, with matching imem_rdata.
REQ-038 instr_ready=0, DEPTH=4 -> exactly 4 requests (0..C), then imem_req stays 0 with count=4; raise instr_ready for one cycle -> one pop, then a request to 0x10.
REQ-039 redirect_pc=0x0000_0103 during WAIT_ACK for addr 0x8, ack 3 cycles later -> FSM DROP, data dropped, instr_valid=0; next request addr 0x100.
REQ-040 Redirect on the same cycle as imem_ack and instr_ready with count=2 -> count=0 next cycle, nothing pushed or popped, next imem_addr = target.
REQ-041 redirect_pc=0xFFFF_FFFC, two acks -> instr_pc FFFF_FFFC then 0000_0000.
REQ-042 rst_n low mid-WAIT_ACK, with ack arriving during reset -> all outputs at reset values, no push; first request after release is to RESET_PC.

Source files
------------

// File: rtl/pc_fetch_queue_if.sv
// Fetch-unit bus: instruction-memory request/ack channel on one side,
// head-of-queue instruction stream and redirect on the other.
interface pc_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/pc_fetch_queue.sv
// Instruction fetch unit: sequential PC generator with a single outstanding
// memory request feeding a small circular queue of {pc, instr} entries.
// A redirect flushes the queue; an in-flight request is always completed
// (DROP state) so the memory handshake is never abandoned mid-flight.
module pc_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pc_fetch_queue_if.master    bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_ACK = 2'd1,
        DROP     = 2'd2
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [31:0]        fetchPc;
    logic [31:0]        reqAddr;
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        qPc    [DEPTH];
    logic [31:0]        qInstr [DEPTH];

    logic               issue;
    logic               push;
    logic               pop;
    logic               headValid;
    logic               imemReq;
    logic [31:0]        redirectTarget;

    // Only RUN issues, so nothing is outstanding there and count < DEPTH
    // guarantees room for the reply. rst_n gating keeps imem_req low in reset.
    assign issue          = rst_n && (state == RUN) && (count < FULL) && !bus.redirect;
    assign push           = (state == WAIT_ACK) && bus.imem_ack && !bus.redirect;
    assign headValid      = (count != '0);
    assign pop            = headValid && bus.instr_ready && !bus.redirect;
    assign redirectTarget = {bus.redirect_pc[31:2], 2'b00};

    // Next-state and request strobe.
    always_comb begin
        stateNext = state;
        imemReq   = 1'b0;
        case (state)
            RUN: begin
                imemReq = issue;
                if (issue) stateNext = WAIT_ACK;
            end
            WAIT_ACK: begin
                imemReq = 1'b1;
                if (bus.imem_ack)     stateNext = RUN;
                else if (bus.redirect) stateNext = DROP;
            end
            DROP: begin
                imemReq = 1'b1;
                if (bus.imem_ack) stateNext = RUN;
            end
            default: stateNext = RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= stateNext;
    end

    // Fetch PC, latched request address, queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc <= RESET_PC;
            reqAddr <= RESET_PC;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
        end else begin
            if (issue) reqAddr <= fetchPc;

            if (bus.redirect)  fetchPc <= redirectTarget;
            else if (push)     fetchPc <= fetchPc + 32'd4;

            if (bus.redirect) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + PTR_W'(1);
                if (pop)  rdPtr <= rdPtr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end
        end
    end

    // Queue storage; contents are qualified by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            qPc[wrPtr]    <= reqAddr;
            qInstr[wrPtr] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req    = imemReq;
    assign bus.imem_addr   = (state == RUN) ? fetchPc : reqAddr;
    assign bus.instr_valid = headValid;
    assign bus.instr       = headValid ? qInstr[rdPtr] : 32'h0;
    assign bus.instr_pc    = headValid ? qPc[rdPtr]    : 32'h0;
endmodule

// File: tb/tb_pc_fetch_queue.sv
// Directed bench for pc_fetch_queue: a table of per-cycle vectors for the
// streaming case, plus hand-written sequences for fill/stall, redirects,
// address wrap and reset during an outstanding request.
module tb_pc_fetch_queue;
    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    pc_fetch_queue_if bus ();

    pc_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] eInstr;
        logic [31:0] ePc;
    } vec_t;

    vec_t vecs [9];

    localparam logic [31:0] A0 = 32'hA000_0011;
    localparam logic [31:0] A1 = 32'hA000_0022;
    localparam logic [31:0] A2 = 32'hA000_0033;
    localparam logic [31:0] A3 = 32'hA000_0044;
    localparam logic [31:0] D0 = 32'hC0DE_0000;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [31:0] rpc, input logic ack,
                         input logic [31:0] rdata, input logic rdy);
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        bus.instr_ready = rdy;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input logic eReq, input logic [31:0] eAddr,
                             input logic eValid, input logic [31:0] eInstr, input logic [31:0] ePc);
        check({tag, ".req"},   32'(bus.imem_req),    32'(eReq));
        check({tag, ".addr"},  bus.imem_addr,        eAddr);
        check({tag, ".valid"}, 32'(bus.instr_valid), 32'(eValid));
        check({tag, ".instr"}, bus.instr,            eInstr);
        check({tag, ".pc"},    bus.instr_pc,         ePc);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) nextCycle();
        rst_n = 1'b1;
    endtask

    initial begin
        // streaming, ready=1, ack one cycle after each request
        vecs[0] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 32'h0, 1'b1, A0,    1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[2] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, A0,    32'h0};
        vecs[3] = '{1'b0, 32'h0, 1'b1, A1,    1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0};
        vecs[4] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, A1,    32'h4};
        vecs[5] = '{1'b0, 32'h0, 1'b1, A2,    1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0};
        vecs[6] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, A2,    32'h8};
        vecs[7] = '{1'b0, 32'h0, 1'b1, A3,    1'b1, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0};
        vecs[8] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, A3,   32'hC};

        // asynchronous reset values
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        expectOut("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("reset.count", 32'(dut.count), 32'd0);
        check("reset.state", 32'(dut.state), 32'd0);
        repeat (2) nextCycle();
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rd, vecs[i].rpc, vecs[i].ack, vecs[i].rdata, vecs[i].rdy);
            #1;
            expectOut($sformatf("vec%0d", i), vecs[i].eReq, vecs[i].eAddr,
                      vecs[i].eValid, vecs[i].eInstr, vecs[i].ePc);
            nextCycle();
        end

        // fill to DEPTH with consumer stalled, then one pop
        doReset();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'(4 * i);
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            #1;
            expectOut($sformatf("fill%0d.issue", i), 1'b1, a, i != 0, (i != 0) ? D0 : 32'h0, 32'h0);
            nextCycle();
            drive(1'b0, 32'h0, 1'b1, D0 + 32'(i), 1'b0);
            #1;
            expectOut($sformatf("fill%0d.ack", i), 1'b1, a, i != 0, (i != 0) ? D0 : 32'h0, 32'h0);
            nextCycle();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        expectOut("full0", 1'b0, 32'h10, 1'b1, D0, 32'h0);
        check("full0.count", 32'(dut.count), 32'd4);
        nextCycle();
        #1;
        expectOut("full1", 1'b0, 32'h10, 1'b1, D0, 32'h0);
        nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        expectOut("popcyc", 1'b0, 32'h10, 1'b1, D0, 32'h0);
        nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        expectOut("afterpop", 1'b1, 32'h10, 1'b1, D0 + 32'd1, 32'h4);
        check("afterpop.count", 32'(dut.count), 32'd3);

        // redirect during WAIT_ACK for 0x8, ack three cycles later
        doReset();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1; expectOut("drp.c0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0); nextCycle();
        drive(1'b0, 32'h0, 1'b1, D0, 1'b0);    #1; expectOut("drp.c1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0); nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1; expectOut("drp.c2", 1'b1, 32'h4, 1'b1, D0, 32'h0); nextCycle();
        drive(1'b0, 32'h0, 1'b1, A1, 1'b0);    #1; expectOut("drp.c3", 1'b1, 32'h4, 1'b1, D0, 32'h0); nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1; expectOut("drp.c4", 1'b1, 32'h8, 1'b1, D0, 32'h0); nextCycle();
        drive(1'b1, 32'h0000_0103, 1'b0, 32'h0, 1'b0); #1; expectOut("drp.c5", 1'b1, 32'h8, 1'b1, D0, 32'h0); nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1; expectOut("drp.c6", 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
        check("drp.c6.state", 32'(dut.state), 32'd2);
        check("drp.c6.count", 32'(dut.count), 32'd0);
        nextCycle();
        #1; expectOut("drp.c7", 1'b1, 32'h8, 1'b0, 32'h0, 32'h0); nextCycle();
        drive(1'b0, 32'h0, 1'b1, BAD, 1'b0); #1; expectOut("drp.c8", 1'b1, 32'h8, 1'b0, 32'h0, 32'h0); nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1; expectOut("drp.c9", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        check("drp.c9.state", 32'(dut.state), 32'd0);
        check("drp.c9.count", 32'(dut.count), 32'd0);

        // redirect coincident with ack and ready, count=2
        doReset();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1; nextCycle();
        drive(1'b0, 32'h0, 1'b1, D0, 1'b0);    #1; nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1; nextCycle();
        drive(1'b0, 32'h0, 1'b1, A1, 1'b0);    #1; nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check("coin.pre.count", 32'(dut.count), 32'd2);
        nextCycle();
        drive(1'b1, 32'h0000_0200, 1'b1, A2, 1'b1); #1;
        expectOut("coin.c5", 1'b1, 32'h8, 1'b1, D0, 32'h0);
        nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        expectOut("coin.c6", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
        check("coin.c6.count", 32'(dut.count), 32'd0);

        // second redirect while in DROP retargets fetch
        doReset();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1; expectOut("rr.c0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0); nextCycle();
        drive(1'b1, 32'h50, 1'b0, 32'h0, 1'b0); #1; expectOut("rr.c1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0); nextCycle();
        drive(1'b1, 32'h63, 1'b0, 32'h0, 1'b0); #1;
        check("rr.c2.state", 32'(dut.state), 32'd2);
        expectOut("rr.c2", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        drive(1'b0, 32'h0, 1'b1, BAD, 1'b0); #1;
        check("rr.c3.state", 32'(dut.state), 32'd2);
        nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        expectOut("rr.c4", 1'b1, 32'h60, 1'b0, 32'h0, 32'h0);

        // redirect in RUN to the top of the address space, then wrap
        doReset();
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1); #1; expectOut("wrap.c0", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0); nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); #1; expectOut("wrap.c1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0); nextCycle();
        drive(1'b0, 32'h0, 1'b1, A0, 1'b1);    #1; expectOut("wrap.c2", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0); nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); #1; expectOut("wrap.c3", 1'b1, 32'h0, 1'b1, A0, 32'hFFFF_FFFC); nextCycle();
        drive(1'b0, 32'h0, 1'b1, A1, 1'b1);    #1; expectOut("wrap.c4", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0); nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); #1; expectOut("wrap.c5", 1'b1, 32'h4, 1'b1, A1, 32'h0);

        // reset asserted mid-WAIT_ACK with an ack arriving during reset
        doReset();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1; nextCycle();
        drive(1'b0, 32'h0, 1'b1, D0, 1'b0);    #1; nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1; expectOut("rst.c2", 1'b1, 32'h4, 1'b1, D0, 32'h0); nextCycle();
        rst_n = 1'b0;
        #1;
        expectOut("rst.async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("rst.async.count", 32'(dut.count), 32'd0);
        check("rst.async.state", 32'(dut.state), 32'd0);
        nextCycle();
        drive(1'b0, 32'h0, 1'b1, BAD, 1'b0); #1;
        expectOut("rst.ack", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        #1;
        expectOut("rst.rel", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        check("rst.rel.count", 32'(dut.count), 32'd0);
        nextCycle();
        drive(1'b0, 32'h0, 1'b1, A3, 1'b0); #1; expectOut("rst.ack2", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0); nextCycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1; expectOut("rst.post", 1'b1, 32'h4, 1'b1, A3, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
